// File: rtl/mem_line_xfer.sv
// Line-transfer engine: turns one whole-line fill or writeback into a burst of
// single-word ren/wen accesses on a simple word-addressed memory port.
module mem_line_xfer #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_W-1:0]                req_line_addr,
    input  logic [WORDS_PER_LINE*DATA_W-1:0] wr_line,
    output logic [WORDS_PER_LINE*DATA_W-1:0] rd_line,
    output logic                             done,
    output logic                             busy,
    output logic                             mem_ren,
    output logic                             mem_wen,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_din,
    input  logic [DATA_W-1:0]                mem_dout,
    output logic [2:0]                       dbg_state
);

    localparam int LW     = $clog2(WORDS_PER_LINE);
    localparam int LINE_W = WORDS_PER_LINE * DATA_W;
    localparam logic [LW-1:0]     K_LAST     = LW'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ   = 3'd2,
        S_RDLAST = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       k_q, k_d;
    logic [LW-1:0]       k_inc;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LINE_W-1:0]   wr_line_q, wr_line_d;
    logic [LINE_W-1:0]   rd_line_q, rd_line_d;
    logic                mem_ren_q, mem_ren_d;
    logic                mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic                accept;

    assign req_ready = (state_q == S_IDLE) && rst;
    assign accept    = req_valid && req_ready;
    assign k_inc     = k_q + 1'b1;

    // Strobes, address and write data are registered: the values computed here
    // describe the access that appears on the memory port in the next cycle.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        base_d     = base_q;
        wr_line_d  = wr_line_q;
        rd_line_d  = rd_line_q;
        mem_ren_d  = 1'b0;
        mem_wen_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    base_d     = req_line_addr & LINE_MASK;
                    wr_line_d  = wr_line;
                    k_d        = '0;
                    mem_addr_d = req_line_addr & LINE_MASK;
                    if (req_write) begin
                        state_d   = S_WRITE;
                        mem_wen_d = 1'b1;
                        mem_din_d = wr_line[DATA_W-1:0];
                    end else begin
                        state_d   = S_READ;
                        mem_ren_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                    k_d     = '0;
                end else begin
                    k_d        = k_inc;
                    mem_wen_d  = 1'b1;
                    mem_addr_d = base_q + ADDR_W'(k_inc);
                    mem_din_d  = wr_line_q[int'(k_inc)*DATA_W +: DATA_W];
                end
            end
            S_READ: begin
                // Read data lags the strobe by one cycle, so word k-1 lands now.
                if (k_q != '0) begin
                    rd_line_d[(int'(k_q) - 1)*DATA_W +: DATA_W] = mem_dout;
                end
                if (k_q == K_LAST) begin
                    state_d = S_RDLAST;
                end else begin
                    k_d        = k_inc;
                    mem_ren_d  = 1'b1;
                    mem_addr_d = base_q + ADDR_W'(k_inc);
                end
            end
            S_RDLAST: begin
                rd_line_d[int'(k_q)*DATA_W +: DATA_W] = mem_dout;
                state_d = S_DONE;
                k_d     = '0;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            base_q     <= '0;
            wr_line_q  <= '0;
            rd_line_q  <= '0;
            mem_ren_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            base_q     <= base_d;
            wr_line_q  <= wr_line_d;
            rd_line_q  <= rd_line_d;
            mem_ren_q  <= mem_ren_d;
            mem_wen_q  <= mem_wen_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign rd_line   = rd_line_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign dbg_state = state_q;

endmodule

// File: doc/mem_line_xfer.md
# mem_line_xfer

Memory-side line-transfer engine for the cache controller. Accepts one whole-line fill (read) or writeback (write) request from the cache and converts it into a sequence of single-word `ren`/`wen` accesses toward the word-addressed main memory model. Read data comes back one cycle after `ren`, and the block reassembles it into a line. It is the initiator for the memory's simple `ren`/`wen`/`addr`/`din`/`dout` port.

## Interface
Parameters:
- `WORDS_PER_LINE`, default 4: words per cache line; must be a power of 2, ≥2.
- `ADDR_W`, default 32: word-address width.
- `DATA_W`, default 32: word width.

Ports:
- `clk`  in  1  — single clock, all logic on posedge.
- `rst`  in  1  — synchronous, active-low reset (low = reset).
- `req_valid`  in  1  — cache requests a line transfer.
- `req_ready`  out  1  — block can accept; high only in IDLE with `rst` high.
- `req_write`  in  1  — 1 = writeback, 0 = fill.
- `req_line_addr`  in  ADDR_W  — any word address inside the target line; low log2(WORDS_PER_LINE) bits are ignored.
- `wr_line`  in  WORDS_PER_LINE*DATA_W  — writeback data; word k at `[k*DATA_W +: DATA_W]`.
- `rd_line`  out  WORDS_PER_LINE*DATA_W  — fill data, same packing.
- `done`  out  1  — one-cycle completion pulse.
- `busy`  out  1  — high whenever not in IDLE.
- `mem_ren`, `mem_wen`  out  1  — memory read/write strobes.
- `mem_addr`  out  ADDR_W  — memory word address.
- `mem_din`  out  DATA_W  — memory write data.
- `mem_dout`  in  DATA_W  — memory read data, valid the cycle after `mem_ren`.

## Operation
- FSM states: IDLE, WRITE, READ, RDLAST, DONE.
- IDLE: when `req_valid && req_ready`, the block latches `base = req_line_addr` with low bits zeroed, `req_write`, and `wr_line`. It clears the word counter `k` and goes to WRITE or READ.
- WRITE: drives `mem_wen=1`, `mem_addr=base+k`, `mem_din=wr_line word k`, with `k` incrementing every cycle. After word N-1 it goes to DONE.
- READ: drives `mem_ren=1`, `mem_addr=base+k` every cycle. `mem_dout` is captured into `rd_line` word k-1 on each edge after the first issue. After issuing word N-1 it goes to RDLAST.
- RDLAST: no strobes. Word N-1 is captured at the end of this cycle, then the FSM goes to DONE.
- DONE: `done=1` for one cycle, then IDLE. On a fill, `rd_line` is complete when `done` is high. `rd_line` holds its value until the next fill overwrites it; writebacks do not alter it.
- `mem_ren` and `mem_wen` are never both high.
- `mem_din` is 0 whenever `mem_wen` is 0.
- Request inputs are sampled only at acceptance; changes while busy are ignored.
- Address arithmetic is mod 2^ADDR_W. Because `base` is line-aligned, `base+k` never wraps within a line.

## Timing
- Reset (`rst` low at an edge): state becomes IDLE. `mem_ren=0`, `mem_wen=0`, `mem_addr=0`, `mem_din=0`, `rd_line=0`, `done=0`, `busy=0`, `k=0`. `req_ready=0` while `rst` is low.
- Reset mid-transfer abandons the transfer: no `done`, and strobes are low from the next cycle. Memory words already written stay written.
- The acceptance edge is t0. Memory strobes are registered outputs.
- Write: `mem_wen` is high in cycles 1..N, `done` in cycle N+1, `req_ready` again in cycle N+2.
- Read: `mem_ren` is high in cycles 1..N, and words are captured at the ends of cycles 2..N+1. `done` is in cycle N+2 and `req_ready` in cycle N+3.
- Back-to-back throughput is one line per N+2 (write) or N+3 (read) cycles.

## Test plan
- Reset: hold `rst` low for 3 cycles with `req_valid=1`. Required: `req_ready=0`, no strobes, `rd_line=0`, `busy=0`. In the first cycle after release, `req_ready=1`.
- Writeback, N=4: `req_line_addr=0x13`, `wr_line` words A0,A1,A2,A3. Required: `mem_wen` in cycles 1–4, `mem_addr` 0x10–0x13, `mem_din` A0–A3; `done` in cycle 5; `req_ready` in cycle 6.
- Fill, against the behavioural memory after the writeback above: `req_line_addr=0x10`. Required: `mem_ren` in cycles 1–4 with addresses 0x10–0x13; `done` in cycle 6; `rd_line` = {A3,A2,A1,A0}.
- Request stability: hold `req_valid` high and change `req_line_addr` and `wr_line` during the transfer. Required: the transfer uses the latched values, and the second request is accepted only in the IDLE cycle after `done`.
- Reset during a fill: drive `rst` low at cycle 2. Required: no strobes from cycle 3, no `done`, `rd_line=0`. A subsequent fill completes correctly.
- Top-of-space: a fill with `req_line_addr=0xFFFFFFFE`. Required: addresses 0xFFFFFFFC–0xFFFFFFFF with no wrap, and `done` in cycle 6.
